// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU memory responder: FSM encoding and TLB latency limits.
package lsu_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StTranslate = 3'd1,
    StHit       = 3'd2,
    StIssue     = 3'd3,
    StWaitRd    = 3'd4,
    StDrain     = 3'd5
  } lsu_state_e;

  localparam int unsigned TlbCntW   = 3;
  localparam int unsigned TlbLatMin = 1;
  localparam int unsigned TlbLatMax = 7;

  function automatic bit tlb_lat_ok(input int unsigned lat);
    return (lat >= TlbLatMin) && (lat <= TlbLatMax);
  endfunction

endpackage

// File: rtl/lsu_mem_responder_if.sv
// LSU request/response and L1 data-cache port bundle; names are from the responder's view.
interface lsu_mem_responder_if #(
  parameter int unsigned VADDR_W = 39,
  parameter int unsigned PADDR_W = 40,
  parameter int unsigned DATA_W  = 64
);
  logic               trns_req_i;
  logic [VADDR_W-1:0] vaddr_i;
  logic               is_store_i;
  logic [DATA_W-1:0]  wdata_i;
  logic               mem_req_valid_i;
  logic               kill_i;
  logic               dtlb_hit_o;
  logic               ld_resp_gnt_o;
  logic               ld_resp_valid_o;
  logic [DATA_W-1:0]  ld_data_o;
  logic               st_resp_gnt_o;
  logic               dc_req_o;
  logic               dc_we_o;
  logic [PADDR_W-1:0] dc_addr_o;
  logic [DATA_W-1:0]  dc_wdata_o;
  logic               dc_gnt_i;
  logic               dc_rvalid_i;
  logic [DATA_W-1:0]  dc_rdata_i;

  // Responder side.
  modport slave (
    input  trns_req_i, vaddr_i, is_store_i, wdata_i, mem_req_valid_i, kill_i,
    output dtlb_hit_o, ld_resp_gnt_o, ld_resp_valid_o, ld_data_o, st_resp_gnt_o,
    output dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o,
    input  dc_gnt_i, dc_rvalid_i, dc_rdata_i
  );

  // LSU FSM plus cache model side.
  modport master (
    output trns_req_i, vaddr_i, is_store_i, wdata_i, mem_req_valid_i, kill_i,
    input  dtlb_hit_o, ld_resp_gnt_o, ld_resp_valid_o, ld_data_o, st_resp_gnt_o,
    input  dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o,
    output dc_gnt_i, dc_rvalid_i, dc_rdata_i
  );
endinterface

// File: rtl/lsu_tlb_stub.sv
// Fixed-latency bare-mode translation; a real TLB can replace it behind start/active/hit.
module lsu_tlb_stub
  import lsu_pkg::*;
#(
  parameter int unsigned VADDR_W = 39,
  parameter int unsigned PADDR_W = 40,
  parameter int unsigned TLB_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               active_i,
  input  logic [VADDR_W-1:0] vaddr_i,
  output logic               hit_o,
  output logic [PADDR_W-1:0] paddr_o
);

  localparam logic [TlbCntW-1:0] LastCnt = TlbCntW'(TLB_LAT - 1);

  logic [TlbCntW-1:0] cnt_q, cnt_d;
  logic               hit_q, hit_d;

  // The hit is registered, so the FSM sees it one cycle after the count reaches its end.
  always_comb begin
    cnt_d = cnt_q;
    hit_d = 1'b0;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i) begin
      cnt_d = cnt_q + 1'b1;
      hit_d = (cnt_q == LastCnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      hit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o   = hit_q;
  assign paddr_o = PADDR_W'(vaddr_i);

endmodule

// File: rtl/lsu_mem_responder.sv
// Serves LSU translation and load/store requests, forwarding one at a time to the L1 D-cache.
module lsu_mem_responder
  import lsu_pkg::*;
#(
  parameter int unsigned VADDR_W = 39,
  parameter int unsigned PADDR_W = 40,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TLB_LAT = 2
) (
  input logic                clk,
  input logic                rst,
  lsu_mem_responder_if.slave bus
);

  if (!tlb_lat_ok(TLB_LAT)) begin : g_bad_tlb_lat
    $error("TLB_LAT must be within 1..7");
  end

  lsu_state_e         state_q, state_d;
  logic [VADDR_W-1:0] vaddr_q, vaddr_d;
  logic               is_store_q, is_store_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               dtlb_hit_q, dtlb_hit_d;
  logic               ld_gnt_q, ld_gnt_d;
  logic               ld_valid_q, ld_valid_d;
  logic [DATA_W-1:0]  ld_data_q, ld_data_d;
  logic               st_gnt_q, st_gnt_d;
  logic               dc_req_q, dc_req_d;
  logic               dc_we_q, dc_we_d;
  logic [PADDR_W-1:0] dc_addr_q, dc_addr_d;
  logic [DATA_W-1:0]  dc_wdata_q, dc_wdata_d;

  logic               tlb_start, tlb_active, tlb_hit;
  logic [PADDR_W-1:0] paddr;

  assign tlb_active = (state_q == StTranslate) && !bus.kill_i;

  lsu_tlb_stub #(
    .VADDR_W (VADDR_W),
    .PADDR_W (PADDR_W),
    .TLB_LAT (TLB_LAT)
  ) u_tlb (
    .clk      (clk),
    .rst      (rst),
    .start_i  (tlb_start),
    .active_i (tlb_active),
    .vaddr_i  (vaddr_q),
    .hit_o    (tlb_hit),
    .paddr_o  (paddr)
  );

  always_comb begin
    state_d    = state_q;
    vaddr_d    = vaddr_q;
    is_store_d = is_store_q;
    wdata_d    = wdata_q;
    dtlb_hit_d = 1'b0;
    ld_gnt_d   = 1'b0;
    ld_valid_d = 1'b0;
    st_gnt_d   = 1'b0;
    ld_data_d  = ld_data_q;
    dc_req_d   = dc_req_q;
    dc_we_d    = dc_we_q;
    dc_addr_d  = dc_addr_q;
    dc_wdata_d = dc_wdata_q;
    tlb_start  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.trns_req_i && !bus.kill_i) begin
          vaddr_d    = bus.vaddr_i;
          is_store_d = bus.is_store_i;
          wdata_d    = bus.wdata_i;
          tlb_start  = 1'b1;
          state_d    = StTranslate;
        end
      end
      StTranslate: begin
        if (bus.kill_i) begin
          state_d = StIdle;
        end else if (tlb_hit) begin
          dtlb_hit_d = 1'b1;
          state_d    = StHit;
        end
      end
      StHit: begin
        if (bus.kill_i) begin
          state_d = StIdle;
        end else if (bus.mem_req_valid_i) begin
          dc_req_d   = 1'b1;
          dc_we_d    = is_store_q;
          dc_addr_d  = paddr;
          dc_wdata_d = wdata_q;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        // A grant beats a same-cycle kill: the cache already owns the transaction.
        if (bus.dc_gnt_i) begin
          dc_req_d = 1'b0;
          if (is_store_q) begin
            st_gnt_d = 1'b1;
            state_d  = StIdle;
          end else if (bus.kill_i) begin
            state_d = StDrain;
          end else begin
            ld_gnt_d = 1'b1;
            state_d  = StWaitRd;
          end
        end else if (bus.kill_i) begin
          dc_req_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StWaitRd: begin
        // Kill with rvalid in the same cycle has nothing left to drain.
        if (bus.kill_i) begin
          state_d = bus.dc_rvalid_i ? StIdle : StDrain;
        end else if (bus.dc_rvalid_i) begin
          ld_data_d  = bus.dc_rdata_i;
          ld_valid_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StDrain: begin
        if (bus.dc_rvalid_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      vaddr_q    <= '0;
      is_store_q <= 1'b0;
      wdata_q    <= '0;
      dtlb_hit_q <= 1'b0;
      ld_gnt_q   <= 1'b0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= '0;
      st_gnt_q   <= 1'b0;
      dc_req_q   <= 1'b0;
      dc_we_q    <= 1'b0;
      dc_addr_q  <= '0;
      dc_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      vaddr_q    <= vaddr_d;
      is_store_q <= is_store_d;
      wdata_q    <= wdata_d;
      dtlb_hit_q <= dtlb_hit_d;
      ld_gnt_q   <= ld_gnt_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
      st_gnt_q   <= st_gnt_d;
      dc_req_q   <= dc_req_d;
      dc_we_q    <= dc_we_d;
      dc_addr_q  <= dc_addr_d;
      dc_wdata_q <= dc_wdata_d;
    end
  end

  assign bus.dtlb_hit_o      = dtlb_hit_q;
  assign bus.ld_resp_gnt_o   = ld_gnt_q;
  assign bus.ld_resp_valid_o = ld_valid_q;
  assign bus.ld_data_o       = ld_data_q;
  assign bus.st_resp_gnt_o   = st_gnt_q;
  assign bus.dc_req_o        = dc_req_q;
  assign bus.dc_we_o         = dc_we_q;
  assign bus.dc_addr_o       = dc_addr_q;
  assign bus.dc_wdata_o      = dc_wdata_q;

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: expected response pulses are queued as stimulus is driven.
module tb_lsu_mem_responder;

  localparam int unsigned VaddrW = 39;
  localparam int unsigned PaddrW = 40;
  localparam int unsigned DataW  = 64;
  localparam int unsigned TlbLat = 2;

  localparam logic [3:0] EvHit   = 4'b1000;
  localparam logic [3:0] EvLdGnt = 4'b0100;
  localparam logic [3:0] EvLdVal = 4'b0010;
  localparam logic [3:0] EvStGnt = 4'b0001;

  typedef struct packed {
    logic [3:0]  kind;
    logic [63:0] data;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  evt_t        exp_q[$];
  int unsigned t0;

  lsu_mem_responder_if #(.VADDR_W(VaddrW), .PADDR_W(PaddrW), .DATA_W(DataW)) bus ();

  lsu_mem_responder #(
    .VADDR_W (VaddrW),
    .PADDR_W (PaddrW),
    .DATA_W  (DataW),
    .TLB_LAT (TlbLat)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_evt(input logic [3:0] kind, input logic [63:0] data);
    evt_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [3:0] p;
    evt_t       e;
    p = {bus.dtlb_hit_o, bus.ld_resp_gnt_o, bus.ld_resp_valid_o, bus.st_resp_gnt_o};
    if (p != 4'b0000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'(p), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", 64'(p), 64'(e.kind));
        if (e.kind == EvLdVal) check("ld_data", bus.ld_data_o, e.data);
      end
    end
  end

  task automatic start_trans(input logic [VaddrW-1:0] a, input logic st, input logic [63:0] wd,
                             input bit exp_hit, output int unsigned t_start);
    if (exp_hit) expect_evt(EvHit, 64'd0);
    bus.vaddr_i    = a;
    bus.is_store_i = st;
    bus.wdata_i    = wd;
    bus.trns_req_i = 1'b1;
    @(negedge clk);
    bus.trns_req_i = 1'b0;
    t_start        = cyc;
  endtask

  task automatic wait_hit(input int unsigned t_start, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.dtlb_hit_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_hit_seen"}, 64'(seen), 64'd1);
    if (seen) check({tag, "_hit_lat"}, 64'(cyc - t_start), 64'(TlbLat + 1));
  endtask

  task automatic issue(input string tag);
    bus.mem_req_valid_i = 1'b1;
    @(negedge clk);
    bus.mem_req_valid_i = 1'b0;
    check({tag, "_dc_req"}, 64'(bus.dc_req_o), 64'd1);
  endtask

  task automatic drive_cache(input logic gnt, input logic kill, input logic rv,
                             input logic [63:0] rdata);
    bus.dc_gnt_i    = gnt;
    bus.kill_i      = kill;
    bus.dc_rvalid_i = rv;
    bus.dc_rdata_i  = rdata;
    @(negedge clk);
    bus.dc_gnt_i    = 1'b0;
    bus.kill_i      = 1'b0;
    bus.dc_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    bus.trns_req_i      = 1'b0;
    bus.vaddr_i         = '0;
    bus.is_store_i      = 1'b0;
    bus.wdata_i         = '0;
    bus.mem_req_valid_i = 1'b0;
    bus.kill_i          = 1'b0;
    bus.dc_gnt_i        = 1'b0;
    bus.dc_rvalid_i     = 1'b0;
    bus.dc_rdata_i      = '0;
    repeat (2) @(negedge clk);
    check("rst_dc_req", 64'(bus.dc_req_o), 64'd0);
    check("rst_dc_addr", 64'(bus.dc_addr_o), 64'd0);
    check("rst_ld_data", bus.ld_data_o, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Load with zero-wait grant.
    start_trans(39'h10_0000_0040, 1'b0, 64'd0, 1'b1, t0);
    wait_hit(t0, "ld1");
    issue("ld1");
    check("ld1_addr", 64'(bus.dc_addr_o), 64'h10_0000_0040);
    check("ld1_we", 64'(bus.dc_we_o), 64'd0);
    expect_evt(EvLdGnt, 64'd0);
    drive_cache(1'b1, 1'b0, 1'b0, 64'd0);
    check("ld1_req_drop", 64'(bus.dc_req_o), 64'd0);
    expect_evt(EvLdVal, 64'hDEAD_BEEF_0000_0001);
    drive_cache(1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    check("ld1_data_hold", bus.ld_data_o, 64'hDEAD_BEEF_0000_0001);

    // Store with three wait cycles before grant.
    start_trans(39'h00_0000_1000, 1'b1, 64'h55AA, 1'b1, t0);
    wait_hit(t0, "st1");
    issue("st1");
    for (int i = 0; i < 4; i++) begin
      check("st1_req_hold", 64'(bus.dc_req_o), 64'd1);
      check("st1_we", 64'(bus.dc_we_o), 64'd1);
      check("st1_wdata", bus.dc_wdata_o, 64'h55AA);
      check("st1_addr", 64'(bus.dc_addr_o), 64'h1000);
      if (i < 3) @(negedge clk);
    end
    expect_evt(EvStGnt, 64'd0);
    drive_cache(1'b1, 1'b0, 1'b0, 64'd0);
    check("st1_req_drop", 64'(bus.dc_req_o), 64'd0);

    // Kill during translation; later mem_req_valid in idle must be ignored.
    start_trans(39'h2000, 1'b0, 64'd0, 1'b0, t0);
    drive_cache(1'b0, 1'b1, 1'b0, 64'd0);
    bus.mem_req_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("ktr_no_req", 64'(bus.dc_req_o), 64'd0);
    end
    bus.mem_req_valid_i = 1'b0;

    // Kill while waiting for read data; late rvalid is drained.
    start_trans(39'h3000, 1'b0, 64'd0, 1'b1, t0);
    wait_hit(t0, "kwr");
    issue("kwr");
    expect_evt(EvLdGnt, 64'd0);
    drive_cache(1'b1, 1'b0, 1'b0, 64'd0);
    drive_cache(1'b0, 1'b1, 1'b0, 64'd0);
    repeat (3) @(negedge clk);
    drive_cache(1'b0, 1'b0, 1'b1, 64'h1234);
    check("kwr_data_kept", bus.ld_data_o, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    start_trans(39'h4000, 1'b0, 64'd0, 1'b1, t0);
    wait_hit(t0, "ld2");
    issue("ld2");
    check("ld2_addr", 64'(bus.dc_addr_o), 64'h4000);
    expect_evt(EvLdGnt, 64'd0);
    drive_cache(1'b1, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    expect_evt(EvLdVal, 64'h0BAD_F00D_1234_5678);
    drive_cache(1'b0, 1'b0, 1'b1, 64'h0BAD_F00D_1234_5678);

    // Kill and grant together on a load: no grant pulse, drain the read.
    start_trans(39'h5000, 1'b0, 64'd0, 1'b1, t0);
    wait_hit(t0, "kgl");
    issue("kgl");
    drive_cache(1'b1, 1'b1, 1'b0, 64'd0);
    check("kgl_req_drop", 64'(bus.dc_req_o), 64'd0);
    // Still draining, so a new translation request must not be taken.
    start_trans(39'h5100, 1'b0, 64'd0, 1'b0, t0);
    repeat (4) @(negedge clk);
    drive_cache(1'b0, 1'b0, 1'b1, 64'hFFFF);
    check("kgl_data_kept", bus.ld_data_o, 64'h0BAD_F00D_1234_5678);
    @(negedge clk);

    // Kill and grant together on a store: the store completes.
    start_trans(39'h6000, 1'b1, 64'hCAFE, 1'b1, t0);
    wait_hit(t0, "kgs");
    issue("kgs");
    expect_evt(EvStGnt, 64'd0);
    drive_cache(1'b1, 1'b1, 1'b0, 64'd0);
    check("kgs_st_gnt", 64'(bus.st_resp_gnt_o), 64'd1);

    // Reset while a request is outstanding.
    start_trans(39'h7000, 1'b1, 64'h7777, 1'b1, t0);
    wait_hit(t0, "rsi");
    issue("rsi");
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("rsi_dc_req", 64'(bus.dc_req_o), 64'd0);
    check("rsi_dc_we", 64'(bus.dc_we_o), 64'd0);
    check("rsi_dc_addr", 64'(bus.dc_addr_o), 64'd0);
    check("rsi_dc_wdata", bus.dc_wdata_o, 64'd0);
    check("rsi_ld_data", bus.ld_data_o, 64'd0);
    drive_cache(1'b1, 1'b0, 1'b1, 64'h77);
    @(negedge clk);
    check("rsi_stray", bus.ld_data_o, 64'd0);
    start_trans(39'h8000, 1'b0, 64'd0, 1'b1, t0);
    wait_hit(t0, "post_rst");

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
